// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) multiply-by-2/4/8 units
// used by the inverse MixColumns sequencer and its column datapath.
package aes_pkg;

  typedef logic [127:0]    state_t;
  typedef logic [3:0][7:0] column_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} ctrl_state_t;

  localparam int         NUM_COLS = 4;
  localparam logic [7:0] GF_POLY  = 8'h1B;

  // xtime: multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] multiply2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] multiply4(input logic [7:0] b);
    return multiply2(multiply2(b));
  endfunction

  function automatic logic [7:0] multiply8(input logic [7:0] b);
    return multiply2(multiply4(b));
  endfunction

endpackage

// File: rtl/inv_mix_col_column.sv
// Combinational single-column (inverse) MixColumns unit.
// Optional MIXCOL_FWD_EN adds a forward-matrix result selected by fwd.
module inv_mix_col_column
  import aes_pkg::*;
(
`ifdef MIXCOL_FWD_EN
  input  logic    fwd,
`endif
  input  column_t col_in,
  output column_t col_out
);

  // a[0] is the top byte of the column (byte 4c), a[3] the bottom one
  logic [7:0] a   [4];
  logic [7:0] x2  [4];
  logic [7:0] x4  [4];
  logic [7:0] x8  [4];
  logic [7:0] m0e [4];
  logic [7:0] m0b [4];
  logic [7:0] m0d [4];
  logic [7:0] m09 [4];
  logic [7:0] inv [4];
`ifdef MIXCOL_FWD_EN
  logic [7:0] fwdr[4];
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]   = col_in[3-i];
      x2[i]  = multiply2(a[i]);
      x4[i]  = multiply4(a[i]);
      x8[i]  = multiply8(a[i]);
      m0e[i] = x8[i] ^ x4[i] ^ x2[i];
      m0b[i] = x8[i] ^ x2[i] ^ a[i];
      m0d[i] = x8[i] ^ x4[i] ^ a[i];
      m09[i] = x8[i] ^ a[i];
    end
    // Each output row is the coefficient row {0e 0b 0d 09} rotated right by its index
    for (int i = 0; i < 4; i++) begin
      inv[i] = m0e[i] ^ m0b[(i+1)%4] ^ m0d[(i+2)%4] ^ m09[(i+3)%4];
    end
`ifdef MIXCOL_FWD_EN
    for (int i = 0; i < 4; i++) begin
      fwdr[i] = x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
    end
`endif
    col_out = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef MIXCOL_FWD_EN
      col_out[3-i] = fwd ? fwdr[i] : inv[i];
`else
      col_out[3-i] = inv[i];
`endif
    end
  end

endmodule

// File: rtl/inv_mix_col_ctrl.sv
// Inverse MixColumns sequencer: one 128-bit state in, COLS_PER_CYCLE columns
// transformed per BUSY cycle, result out. MIXCOL_FWD_EN adds a fwd mode input.
module inv_mix_col_ctrl
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef MIXCOL_FWD_EN
  input  logic         fwd,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
      $error("inv_mix_col_ctrl: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam int LAST_COL = NUM_COLS - COLS_PER_CYCLE;

  ctrl_state_t state, state_nxt;
  logic [1:0]  col;
  state_t      work, work_nxt;
  logic        last_col;
  column_t     col_in  [COLS_PER_CYCLE];
  column_t     col_out [COLS_PER_CYCLE];
`ifdef MIXCOL_FWD_EN
  logic        fwd_q;
`endif

  assign last_col = (col == 2'(LAST_COL));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid)  state_nxt = BUSY;
        BUSY:    if (last_col)  state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    out_data  = (state == DONE) ? work : '0;
  end

  // Column slots: slot g works on column col+g; col is always a multiple of COLS_PER_CYCLE
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_in[g] = work[127-32*(int'(col)+g) -: 32];
    inv_mix_col_column u_col (
`ifdef MIXCOL_FWD_EN
      .fwd     (fwd_q),
`endif
      .col_in  (col_in[g]),
      .col_out (col_out[g])
    );
  end

  always_comb begin
    work_nxt = work;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      work_nxt[127-32*(int'(col)+g) -: 32] = col_out[g];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      work  <= '0;
      col   <= '0;
`ifdef MIXCOL_FWD_EN
      fwd_q <= 1'b0;
`endif
    end else if (clear) begin
      col   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work  <= in_data;
          col   <= '0;
`ifdef MIXCOL_FWD_EN
          fwd_q <= fwd;
`endif
        end
        BUSY: begin
          work <= work_nxt;
          col  <= last_col ? 2'd0 : col + 2'(COLS_PER_CYCLE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_col_ctrl.sv
// Directed bench for inv_mix_col_ctrl: three instances (1, 2, 4 columns per
// cycle) share stimulus; expectations are hand-computed AES column vectors.
module tb_inv_mix_col_ctrl;

  localparam logic [127:0] V_UNI   = {4{32'h8e4da1bc}};
  localparam logic [127:0] EXP_UNI = {4{32'hdb135345}};
  localparam logic [127:0] V_MIX   = {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'h8e4da1bc};
  localparam logic [127:0] EXP_MIX = {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hdb135345};
  localparam logic [127:0] V_FWD   = {4{32'hdb135345}};
  localparam logic [127:0] EXP_FWD = {4{32'h8e4da1bc}};
  localparam logic [127:0] EXP_INV = {4{32'h32a41d55}};

  logic         clk = 1'b0;
  logic         n_rst;
  logic         clear;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
`ifdef MIXCOL_FWD_EN
  logic         fwd;
`endif
  logic         ir1, ir2, ir4;
  logic         ov1, ov2, ov4;
  logic         bz1, bz2, bz4;
  logic [127:0] od1, od2, od4;

  int checks   = 0;
  int failures = 0;
  int lat1, lat2, lat4;
  logic [127:0] d1, d2, d4;

  always #5 clk = ~clk;

  inv_mix_col_ctrl #(.COLS_PER_CYCLE(1)) u1 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data),
`ifdef MIXCOL_FWD_EN
    .fwd(fwd),
`endif
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .busy(bz1));

  inv_mix_col_ctrl #(.COLS_PER_CYCLE(2)) u2 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data),
`ifdef MIXCOL_FWD_EN
    .fwd(fwd),
`endif
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .busy(bz2));

  inv_mix_col_ctrl #(.COLS_PER_CYCLE(4)) u4 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(in_valid), .in_ready(ir4),
    .in_data(in_data),
`ifdef MIXCOL_FWD_EN
    .fwd(fwd),
`endif
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .busy(bz4));

  // Present one word for exactly one edge once all instances are ready
  task automatic send(input logic [127:0] d);
    int n = 0;
    while (!(ir1 && ir2 && ir4) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!(ir1 && ir2 && ir4)) begin
      failures++;
      $display("FAIL send_ready got=%b%b%b exp=111", ir1, ir2, ir4);
    end
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Record edges-after-accept at which each out_valid first rises and the data then
  task automatic capture();
    lat1 = -1; lat2 = -1; lat4 = -1;
    d1 = '0; d2 = '0; d4 = '0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (ov1 && lat1 < 0) begin lat1 = k; d1 = od1; end
      if (ov2 && lat2 < 0) begin lat2 = k; d2 = od2; end
      if (ov4 && lat4 < 0) begin lat4 = k; d4 = od4; end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef MIXCOL_FWD_EN
    fwd = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ir1, ov1, bz1} !== 3'b100) begin
      failures++; $display("FAIL reset_ctrl1 got=%b exp=100", {ir1, ov1, bz1});
    end
    checks++;
    if ({ir2, ov2, bz2, ir4, ov4, bz4} !== 6'b100100) begin
      failures++; $display("FAIL reset_ctrl24 got=%b exp=100100", {ir2, ov2, bz2, ir4, ov4, bz4});
    end
    checks++;
    if ((od1 | od2 | od4) !== 128'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", od1 | od2 | od4);
    end
    n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_busy();
    send(V_UNI);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (bz1 !== 1'b1) begin
      failures++; $display("FAIL midbusy_pre got=%b exp=1", bz1);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if ({ir1, ov1, bz1} !== 3'b100) begin
      failures++; $display("FAIL midbusy_async got=%b exp=100", {ir1, ov1, bz1});
    end
    #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    send(V_UNI);
    capture();
    checks++;
    if (lat1 !== 4 || d1 !== EXP_UNI) begin
      failures++; $display("FAIL midbusy_after got=%0d/%h exp=4/%h", lat1, d1, EXP_UNI);
    end
  endtask

  task automatic test_inv_uniform();
    send(V_UNI);
    capture();
    checks++;
    if (lat1 !== 4) begin failures++; $display("FAIL uni_lat1 got=%0d exp=4", lat1); end
    checks++;
    if (d1 !== EXP_UNI) begin failures++; $display("FAIL uni_data1 got=%h exp=%h", d1, EXP_UNI); end
    checks++;
    if (d2 !== EXP_UNI || d4 !== EXP_UNI) begin
      failures++; $display("FAIL uni_data24 got=%h/%h exp=%h", d2, d4, EXP_UNI);
    end
  endtask

  task automatic test_inv_mixed();
    send(V_MIX);
    capture();
    checks++;
    if (lat2 !== 2) begin failures++; $display("FAIL mix_lat2 got=%0d exp=2", lat2); end
    checks++;
    if (lat4 !== 1) begin failures++; $display("FAIL mix_lat4 got=%0d exp=1", lat4); end
    checks++;
    if (d2 !== EXP_MIX) begin failures++; $display("FAIL mix_data2 got=%h exp=%h", d2, EXP_MIX); end
    checks++;
    if (d4 !== EXP_MIX) begin failures++; $display("FAIL mix_data4 got=%h exp=%h", d4, EXP_MIX); end
    checks++;
    if (d1 !== EXP_MIX) begin failures++; $display("FAIL mix_data1 got=%h exp=%h", d1, EXP_MIX); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(V_MIX);
    repeat (5) begin @(posedge clk); #1; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({ov1, ir1} !== 2'b10 || od1 !== EXP_MIX) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=%b%b/%h exp=10/%h", i, ov1, ir1, od1, EXP_MIX);
      end
      in_data  = V_UNI;
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    checks++;
    if (ov4 !== 1'b1 || od4 !== EXP_MIX) begin
      failures++; $display("FAIL bp_hold4 got=%b/%h exp=1/%h", ov4, od4, EXP_MIX);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ir1, ov1, bz1, ir4, ov4, bz4} !== 6'b100100) begin
      failures++; $display("FAIL bp_release got=%b exp=100100", {ir1, ov1, bz1, ir4, ov4, bz4});
    end
    @(posedge clk); #1;
    checks++;
    if ((bz1 | bz2 | bz4) !== 1'b0) begin
      failures++; $display("FAIL bp_no_accept got=%b exp=0", bz1 | bz2 | bz4);
    end
  endtask

  task automatic test_clear();
    logic seen;
    clear = 1'b1; in_valid = 1'b1; in_data = V_UNI;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    checks++;
    if ({bz1, bz2, bz4, ir1} !== 4'b0001) begin
      failures++; $display("FAIL clr_idle got=%b exp=0001", {bz1, bz2, bz4, ir1});
    end
    send(V_MIX);
    @(posedge clk); #1;
    checks++;
    if (bz1 !== 1'b1) begin failures++; $display("FAIL clr_busy_pre got=%b exp=1", bz1); end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if ({ir1, ov1, bz1, ir2, ov2, bz2} !== 6'b100100) begin
      failures++; $display("FAIL clr_busy got=%b exp=100100", {ir1, ov1, bz1, ir2, ov2, bz2});
    end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      seen = seen | ov1 | ov2 | ov4;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL clr_no_valid got=%b exp=0", seen); end
    send(V_MIX);
    capture();
    checks++;
    if (d1 !== EXP_MIX || lat1 !== 4) begin
      failures++; $display("FAIL clr_after got=%0d/%h exp=4/%h", lat1, d1, EXP_MIX);
    end
  endtask

`ifdef MIXCOL_FWD_EN
  task automatic test_fwd();
    fwd = 1'b1;
    send(V_FWD);
    fwd = 1'b0;
    capture();
    checks++;
    if (d1 !== EXP_FWD || lat1 !== 4) begin
      failures++; $display("FAIL fwd_data1 got=%0d/%h exp=4/%h", lat1, d1, EXP_FWD);
    end
    checks++;
    if (d4 !== EXP_FWD || lat4 !== 1) begin
      failures++; $display("FAIL fwd_data4 got=%0d/%h exp=1/%h", lat4, d4, EXP_FWD);
    end
    send(V_FWD);
    capture();
    checks++;
    if (d1 !== EXP_INV || d2 !== EXP_INV) begin
      failures++; $display("FAIL fwd0_inv got=%h/%h exp=%h", d1, d2, EXP_INV);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_busy();
    test_inv_uniform();
    test_inv_mixed();
    test_backpressure();
    test_clear();
`ifdef MIXCOL_FWD_EN
    test_fwd();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
